operand_loader: RTL

//  Source-side counterpart of the operand capture path. Receives operand bytes serially

---
 rtl/loader_pkg.sv | 18 +
 rtl/operand_regfile.sv | 29 ++
 rtl/operand_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and operand geometry for operand_loader
package loader_pkg;

  localparam int DATA_W      = 8;
  localparam int A_COUNT     = 16;
  localparam int B_COUNT     = 9;
  localparam int TOTAL_COUNT = A_COUNT + B_COUNT;
  localparam int IDX_W       = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_ARM    = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/operand_regfile.sv
// rtl/operand_regfile.sv - single write port operand storage with flat read-out
module operand_regfile
  import loader_pkg::*;
(
  input  logic                            i_clk,
  input  logic                            i_resetn,
  input  logic                            i_we,
  input  logic [IDX_W-1:0]                i_idx,
  input  logic [DATA_W-1:0]               i_data,
  output logic [TOTAL_COUNT*DATA_W-1:0]   o_flat
);

  logic [DATA_W-1:0] r_mem [TOTAL_COUNT];

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int i = 0; i < TOTAL_COUNT; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (int'(i_idx) < TOTAL_COUNT)) begin
      r_mem[i_idx] <= i_data;
    end
  end

  for (genvar g = 0; g < TOTAL_COUNT; g++) begin : g_flat
    assign o_flat[g*DATA_W +: DATA_W] = r_mem[g];
  end

endmodule

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - serial byte loader assembling A/B operands and launching run
module operand_loader
  import loader_pkg::*;
#(
  parameter int RUN_LEN = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           byte_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic                        abort_i,
  input  logic                        release_i,
  output logic [A_COUNT*DATA_W-1:0]   a_flat_o,
  output logic [B_COUNT*DATA_W-1:0]   b_flat_o,
  output logic                        run_o,
  output logic                        busy_o,
  output logic [4:0]                  count_o,
  output logic                        overrun_o
);

  localparam int RUN_W = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;

  state_t                         r_state, w_next;
  logic [4:0]                     r_count, w_count_next;
  logic [RUN_W-1:0]               r_run_cnt, w_run_cnt_next;
  logic                           r_run, r_busy, r_overrun, w_overrun_next;
  logic                           w_xfer, w_we;
  logic [IDX_W-1:0]               w_widx;
  logic [TOTAL_COUNT*DATA_W-1:0]  w_flat;

  assign ready_o = (r_state == ST_IDLE) || (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
  assign w_xfer  = valid_i & ready_o;

  always_comb begin
    w_next         = r_state;
    w_count_next   = r_count;
    w_run_cnt_next = r_run_cnt;
    w_we           = 1'b0;
    w_widx         = r_count;
    // Bytes offered while not ready are dropped but remembered as an overrun.
    w_overrun_next = r_overrun | (valid_i & ~ready_o);
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_we         = 1'b1;
          w_widx       = '0;
          w_count_next = 5'd1;
          w_next       = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        if (abort_i) begin
          w_count_next = '0;
          w_next       = ST_IDLE;
        end else if (w_xfer) begin
          w_we         = 1'b1;
          w_count_next = r_count + 5'd1;
          if (r_count == 5'(A_COUNT - 1)) w_next = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (abort_i) begin
          w_count_next = '0;
          w_next       = ST_IDLE;
        end else if (w_xfer) begin
          w_we         = 1'b1;
          w_count_next = r_count + 5'd1;
          if (r_count == 5'(TOTAL_COUNT - 1)) begin
            w_run_cnt_next = '0;
            w_next         = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        if (r_run_cnt == RUN_W'(RUN_LEN - 1)) begin
          w_next = ST_HOLD;
        end else begin
          w_run_cnt_next = r_run_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (release_i) begin
          w_count_next   = '0;
          w_overrun_next = 1'b0;
          w_next         = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // run/busy are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_run_cnt <= '0;
      r_run     <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_count   <= w_count_next;
      r_run_cnt <= w_run_cnt_next;
      r_run     <= (w_next == ST_ARM);
      r_busy    <= (w_next != ST_IDLE);
      r_overrun <= w_overrun_next;
    end
  end

  operand_regfile u_regfile (
    .i_clk    (clk),
    .i_resetn (reset),
    .i_we     (w_we),
    .i_idx    (w_widx),
    .i_data   (byte_i),
    .o_flat   (w_flat)
  );

  assign a_flat_o  = w_flat[A_COUNT*DATA_W-1:0];
  assign b_flat_o  = w_flat[TOTAL_COUNT*DATA_W-1:A_COUNT*DATA_W];
  assign run_o     = r_run;
  assign busy_o    = r_busy;
  assign count_o   = r_count;
  assign overrun_o = r_overrun;

endmodule
